// File: rtl/hdpldadapt_sr_pkg.sv
// Shared SR chain definitions: chain sizes, state encoding and frame-length rule.
// Used by both the RX deserialiser and the TX SR state machine.
package hdpldadapt_sr_pkg;

    localparam int unsigned NUM_OF_PCS_CHAIN            = 16;
    localparam int unsigned NUM_OF_HIP_CHAIN            = 16;
    localparam int unsigned NUM_OF_RESERVED_CHAIN_SSRIN = 5;
    localparam int unsigned NUM_OF_PARITY_IN            = 1;
    localparam int unsigned LOCK_CNT                    = 2;

    localparam int unsigned DW     = NUM_OF_PCS_CHAIN + NUM_OF_HIP_CHAIN + NUM_OF_RESERVED_CHAIN_SSRIN;
    localparam int unsigned CNT_W  = 7;
    localparam int unsigned GOOD_W = 3;
    localparam int unsigned ERR_W  = 8;
    localparam int unsigned TB_W   = 12;

    typedef enum logic [1:0] {
        ACQ   = 2'b00,
        SHIFT = 2'b01
    } sr_state_e;

    // Bits per frame for a given chain composition; parity only rides when HIP is off.
    function automatic logic [CNT_W-1:0] sr_frame_len(input logic hip_en,
                                                      input logic parity_en,
                                                      input logic reserbits_en);
        int unsigned n;
        n = NUM_OF_PCS_CHAIN;
        if (hip_en)         n = n + NUM_OF_HIP_CHAIN;
        else if (parity_en) n = n + NUM_OF_PARITY_IN;
        if (reserbits_en)   n = n + NUM_OF_RESERVED_CHAIN_SSRIN;
        return CNT_W'(n);
    endfunction

endpackage

// File: rtl/hdpldadapt_sr_rx_lock.sv
// Frame lock tracker: consecutive good-frame counter, lock flag and saturating error count.
module hdpldadapt_sr_rx_lock
    import hdpldadapt_sr_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             good,
    input  logic             err,
    output logic             sr_locked,
    output logic [ERR_W-1:0] sr_err_cnt
);

    logic [GOOD_W-1:0] good_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            good_cnt   <= '0;
            sr_locked  <= 1'b0;
            sr_err_cnt <= '0;
        end else if (err) begin
            good_cnt  <= '0;
            sr_locked <= 1'b0;
            if (sr_err_cnt != '1) sr_err_cnt <= sr_err_cnt + 1'b1;
        end else if (good) begin
            if (good_cnt < GOOD_W'(LOCK_CNT)) good_cnt <= good_cnt + 1'b1;
            if (good_cnt >= GOOD_W'(LOCK_CNT - 1)) sr_locked <= 1'b1;
        end
    end

endmodule

// File: rtl/hdpldadapt_sr_rx_deser.sv
// RX SR deserialiser: frames the serial status stream on sr_loadin and captures parallel words.
// Optional even-parity check on PCS bits enabled by macro HDPLDADAPT_SR_RX_PARITY_CHK_EN.
module hdpldadapt_sr_rx_deser
    import hdpldadapt_sr_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             r_sr_hip_en,
    input  logic             r_sr_parity_en,
    input  logic             r_sr_reserbits_in_en,
    input  logic             avmm_hrdrst_fabric_osc_transfer_en_sync,
    input  logic             sr_loadin,
    input  logic             sr_sdata_in,
    output logic [DW-1:0]    sr_dout,
    output logic             sr_dout_vld,
    output logic             sr_locked,
    output logic             sr_len_err,
    output logic             sr_par_err,
    output logic [ERR_W-1:0] sr_err_cnt,
    output logic [TB_W-1:0]  sr_rx_testbus
);

    sr_state_e        state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [DW-1:0]    shreg, shreg_nxt;
    logic [DW-1:0]    dout_nxt;
    logic             vld_nxt, len_err_nxt, par_err_nxt;
    logic [CNT_W-1:0] frame_len_c;
    logic [DW-1:0]    len_mask_c;
    logic             par_bad_c;
    logic             xfer_en;

    assign xfer_en     = avmm_hrdrst_fabric_osc_transfer_en_sync;
    assign frame_len_c = sr_frame_len(r_sr_hip_en, r_sr_parity_en, r_sr_reserbits_in_en);

    always_comb begin
        len_mask_c = '0;
        for (int i = 0; i < DW; i++) len_mask_c[i] = (CNT_W'(i) < frame_len_c);
    end

`ifdef HDPLDADAPT_SR_RX_PARITY_CHK_EN
    assign par_bad_c = r_sr_parity_en & ~r_sr_hip_en &
                       (shreg[NUM_OF_PCS_CHAIN] != ^shreg[NUM_OF_PCS_CHAIN-1:0]);
`else
    assign par_bad_c = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ACQ;
            cnt         <= '0;
            shreg       <= '0;
            sr_dout     <= '0;
            sr_dout_vld <= 1'b0;
            sr_len_err  <= 1'b0;
            sr_par_err  <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            shreg       <= shreg_nxt;
            sr_dout     <= dout_nxt;
            sr_dout_vld <= vld_nxt;
            sr_len_err  <= len_err_nxt;
            sr_par_err  <= par_err_nxt;
        end
    end

    // Framing: marker closes/opens a frame, overlength drops back to acquisition.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        shreg_nxt   = shreg;
        dout_nxt    = sr_dout;
        vld_nxt     = 1'b0;
        len_err_nxt = 1'b0;
        par_err_nxt = 1'b0;
        if (!xfer_en) begin
            state_nxt = ACQ;
            cnt_nxt   = '0;
            shreg_nxt = '0;
        end else begin
            case (state)
                ACQ: begin
                    if (sr_loadin) begin
                        state_nxt = SHIFT;
                        cnt_nxt   = '0;
                        shreg_nxt = '0;
                    end
                end
                SHIFT: begin
                    if (sr_loadin) begin
                        cnt_nxt   = '0;
                        shreg_nxt = '0;
                        if (cnt == frame_len_c) begin
                            dout_nxt    = shreg & len_mask_c;
                            vld_nxt     = 1'b1;
                            par_err_nxt = par_bad_c;
                        end else begin
                            len_err_nxt = 1'b1;
                        end
                    end else begin
                        for (int i = 0; i < DW; i++) begin
                            if (cnt == CNT_W'(i)) shreg_nxt[i] = sr_sdata_in;
                        end
                        if (cnt != '1) cnt_nxt = cnt + 1'b1;
                        if (cnt >= frame_len_c) begin
                            len_err_nxt = 1'b1;
                            state_nxt   = ACQ;
                        end
                    end
                end
                default: state_nxt = ACQ;
            endcase
        end
    end

    hdpldadapt_sr_rx_lock u_lock (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (~xfer_en),
        .good       (vld_nxt & ~par_err_nxt),
        .err        (len_err_nxt | par_err_nxt),
        .sr_locked  (sr_locked),
        .sr_err_cnt (sr_err_cnt)
    );

    // Debug snapshot of framing status, one cycle behind the live signals.
    always_ff @(posedge clk) begin
        if (!rst_n) sr_rx_testbus <= '0;
        else        sr_rx_testbus <= {xfer_en, state, sr_locked, sr_loadin, cnt};
    end

endmodule

// File: tb/tb_hdpldadapt_sr_rx_deser.sv
// Self-checking bench for hdpldadapt_sr_rx_deser: directed scenarios plus randomized frames
// against a frame-level queue model.
module tb_hdpldadapt_sr_rx_deser;
    import hdpldadapt_sr_pkg::*;

    logic             clk = 1'b0;
    logic             rst_n, hip_en, par_en, rsv_en, xfer, loadin, sdata;
    logic [DW-1:0]    sr_dout;
    logic             sr_dout_vld, sr_locked, sr_len_err, sr_par_err;
    logic [7:0]       sr_err_cnt;
    logic [11:0]      sr_rx_testbus;

    always #5 clk = ~clk;

    hdpldadapt_sr_rx_deser dut (
        .clk                                     (clk),
        .rst_n                                   (rst_n),
        .r_sr_hip_en                             (hip_en),
        .r_sr_parity_en                          (par_en),
        .r_sr_reserbits_in_en                    (rsv_en),
        .avmm_hrdrst_fabric_osc_transfer_en_sync (xfer),
        .sr_loadin                               (loadin),
        .sr_sdata_in                             (sdata),
        .sr_dout                                 (sr_dout),
        .sr_dout_vld                             (sr_dout_vld),
        .sr_locked                               (sr_locked),
        .sr_len_err                              (sr_len_err),
        .sr_par_err                              (sr_par_err),
        .sr_err_cnt                              (sr_err_cnt),
        .sr_rx_testbus                           (sr_rx_testbus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: bits received since the last marker held in a queue.
    bit          m_sync;
    bit          m_q[$];
    logic [63:0] m_dout;
    bit          m_vld, m_len, m_par, m_lock;
    int          m_good, m_errs;

    function automatic int exp_len();
        int n;
        n = 16;
        if (hip_en)      n += 16;
        else if (par_en) n += 1;
        if (rsv_en)      n += 5;
        return n;
    endfunction

    task automatic model_edge(input bit ld, input bit d);
        bit p;
        m_vld = 0; m_len = 0; m_par = 0;
        if (!rst_n) begin
            m_sync = 0; m_q.delete(); m_dout = '0; m_lock = 0; m_good = 0; m_errs = 0;
        end else if (!xfer) begin
            m_sync = 0; m_q.delete(); m_lock = 0; m_good = 0; m_errs = 0;
        end else if (!m_sync) begin
            if (ld) begin m_sync = 1; m_q.delete(); end
        end else if (ld) begin
            if (m_q.size() == exp_len()) begin
                m_dout = '0;
                foreach (m_q[i]) m_dout[i] = m_q[i];
                m_vld = 1;
`ifdef HDPLDADAPT_SR_RX_PARITY_CHK_EN
                if (par_en && !hip_en) begin
                    p = 0;
                    for (int i = 0; i < 16; i++) p ^= m_q[i];
                    m_par = (m_q[16] != p);
                end
`endif
            end else begin
                m_len = 1;
            end
            m_q.delete();
        end else begin
            m_q.push_back(d);
            if (m_q.size() > exp_len()) begin m_len = 1; m_sync = 0; end
        end
        if (m_len || m_par) begin
            m_lock = 0; m_good = 0;
            if (m_errs < 255) m_errs++;
        end else if (m_vld) begin
            m_good++;
            if (m_good >= 2) m_lock = 1;
        end
    endtask

    task automatic tick(input bit ld, input bit d);
        loadin = ld;
        sdata  = d;
        @(posedge clk);
        model_edge(ld, d);
        #1;
        chk("dout",    64'(sr_dout),     m_dout);
        chk("vld",     64'(sr_dout_vld), 64'(m_vld));
        chk("len_err", 64'(sr_len_err),  64'(m_len));
        chk("par_err", 64'(sr_par_err),  64'(m_par));
        chk("locked",  64'(sr_locked),   64'(m_lock));
        chk("err_cnt", 64'(sr_err_cnt),  64'(m_errs));
    endtask

    task automatic send_bits(input logic [63:0] w, input int len);
        for (int i = 0; i < len; i++) tick(1'b0, w[i]);
    endtask

    logic [63:0] w, alt;
    int          len, dl;

    initial begin
        rst_n = 1'b0; hip_en = 1'b0; par_en = 1'b0; rsv_en = 1'b0; xfer = 1'b1;
        loadin = 1'b0; sdata = 1'b0;
        m_sync = 0; m_dout = '0; m_lock = 0; m_good = 0; m_errs = 0;
        tick(1'b0, 1'b1);
        tick(1'b1, 1'b1);
        chk("rst_dout", 64'(sr_dout), 64'h0);
        chk("rst_locked", 64'(sr_locked), 64'h0);
        chk("rst_errcnt", 64'(sr_err_cnt), 64'h0);
        chk("rst_state", 64'(sr_rx_testbus[10:9]), 64'(ACQ));
        rst_n = 1'b1;

        // 16-bit frames of 0xA5C3, lock after the second good frame
        tick(1'b0, 1'b1);
        tick(1'b1, 1'b0);
        for (int f = 0; f < 3; f++) begin
            send_bits(64'hA5C3, 16);
            tick(1'b1, 1'b0);
            chk("t1_dout", 64'(sr_dout), 64'hA5C3);
            chk("t1_vld", 64'(sr_dout_vld), 64'h1);
            chk("t1_lock", 64'(sr_locked), (f >= 1) ? 64'h1 : 64'h0);
        end

        // 37-bit frames, HIP + reserved
        hip_en = 1'b1; rsv_en = 1'b1;
        alt = 64'h15_5555_5555;
        send_bits(alt, 37);
        tick(1'b1, 1'b0);
        chk("t2_dout_a", 64'(sr_dout), alt);
        chk("t2_noerr_a", 64'(sr_len_err), 64'h0);
        send_bits(~alt, 37);
        tick(1'b1, 1'b0);
        chk("t2_dout_b", 64'(sr_dout), ~alt & 64'h1F_FFFF_FFFF);
        chk("t2_errcnt", 64'(sr_err_cnt), 64'h0);

        // Short frame while locked, then overlength run
        hip_en = 1'b0; rsv_en = 1'b0;
        send_bits(64'h1234, 16); tick(1'b1, 1'b0);
        send_bits(64'h3C5A, 16); tick(1'b1, 1'b0);
        chk("t3_locked", 64'(sr_locked), 64'h1);
        send_bits(64'h7FFF, 15); tick(1'b1, 1'b0);
        chk("t3_len_err", 64'(sr_len_err), 64'h1);
        chk("t3_unlock", 64'(sr_locked), 64'h0);
        chk("t3_errcnt", 64'(sr_err_cnt), 64'h1);
        chk("t3_dout_hold", 64'(sr_dout), 64'h3C5A);
        for (int i = 0; i < 20; i++) begin
            tick(1'b0, i[0]);
            chk("t3_ovl_err", 64'(sr_len_err), (i == 16) ? 64'h1 : 64'h0);
        end
        chk("t3_ovl_state", 64'(sr_rx_testbus[10:9]), 64'(ACQ));

        // Parity bit handling (frame of 17 bits)
        par_en = 1'b1;
        tick(1'b1, 1'b0);
`ifdef HDPLDADAPT_SR_RX_PARITY_CHK_EN
        send_bits(64'h1_0001, 17); tick(1'b1, 1'b0);
        send_bits(64'h1_0001, 17); tick(1'b1, 1'b0);
        chk("t4_locked", 64'(sr_locked), 64'h1);
        send_bits(64'h0_0001, 17); tick(1'b1, 1'b0);
        chk("t4_par_err", 64'(sr_par_err), 64'h1);
        chk("t4_vld", 64'(sr_dout_vld), 64'h1);
        chk("t4_unlock", 64'(sr_locked), 64'h0);
        chk("t4_dout", 64'(sr_dout), 64'h0_0001);
        send_bits(64'h1_0001, 17); tick(1'b1, 1'b0);
        chk("t4_par_ok", 64'(sr_par_err), 64'h0);
        chk("t4_dout_ok", 64'(sr_dout), 64'h1_0001);
`else
        send_bits(64'h0_0001, 17); tick(1'b1, 1'b0);
        chk("t4_par_tied", 64'(sr_par_err), 64'h0);
        chk("t4_vld", 64'(sr_dout_vld), 64'h1);
        chk("t4_dout", 64'(sr_dout), 64'h0_0001);
`endif

        // Transfer enable drop mid-frame
        par_en = 1'b0;
        send_bits(64'h0F0F, 17); tick(1'b1, 1'b0);
        send_bits(64'hBEEF, 16); tick(1'b1, 1'b0);
        send_bits(64'hCAFE, 16); tick(1'b1, 1'b0);
        send_bits(64'h00FF, 8);
        xfer = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 1'b1);
            chk("t5_unlock", 64'(sr_locked), 64'h0);
            chk("t5_novld", 64'(sr_dout_vld), 64'h0);
        end
        chk("t5_dout_hold", 64'(sr_dout), 64'hCAFE);
        xfer = 1'b1;
        send_bits(64'h00FF, 8); tick(1'b1, 1'b0);
        chk("t5_reacq_novld", 64'(sr_dout_vld), 64'h0);
        send_bits(64'h1357, 16); tick(1'b1, 1'b0);
        chk("t5_resume_vld", 64'(sr_dout_vld), 64'h1);
        chk("t5_resume_dout", 64'(sr_dout), 64'h1357);

        // Error counter saturation
        for (int i = 0; i < 260; i++) tick(1'b1, 1'b0);
        chk("t6_sat", 64'(sr_err_cnt), 64'hFF);
        tick(1'b1, 1'b0);
        chk("t6_sat_hold", 64'(sr_err_cnt), 64'hFF);

        // Randomized frames, lengths around N, config changes, enable drops, resets
        rst_n = 1'b0; tick(1'b0, 1'b0); rst_n = 1'b1;
        for (int k = 0; k < 200; k++) begin
            if ($urandom_range(7) == 0) begin
                hip_en = 1'($urandom); par_en = 1'($urandom); rsv_en = 1'($urandom);
            end
            if ($urandom_range(15) == 0) begin
                xfer = 1'b0;
                repeat ($urandom_range(3, 1)) tick(1'b0, 1'($urandom));
                xfer = 1'b1;
            end
            if ($urandom_range(63) == 0) begin
                rst_n = 1'b0; tick(1'b0, 1'($urandom)); rst_n = 1'b1;
            end
            dl = $urandom_range(9);
            len = exp_len();
            if (dl == 0)      len = len - 1;
            else if (dl == 1) len = len + 2;
            else if (dl == 2) len = $urandom_range(4);
            w = {$urandom, $urandom};
            send_bits(w, len);
            tick(1'b1, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
